// File: rtl/sram_1rw1r_arbiter.sv
// Front-end for a 1RW+1R SRAM macro: post-reset clear, round-robin sharing of
// port 0 between two clients, port-1 read client, registered read responses.
module sram_1rw1r_arbiter #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_done,
   input  logic                  c0_req_valid,
   output logic                  c0_req_ready,
   input  logic                  c0_req_we,
   input  logic [ADDR_WIDTH-1:0] c0_req_addr,
   input  logic [DATA_WIDTH-1:0] c0_req_wdata,
   output logic                  c0_rsp_valid,
   output logic [DATA_WIDTH-1:0] c0_rsp_data,
   input  logic                  c1_req_valid,
   output logic                  c1_req_ready,
   input  logic                  c1_req_we,
   input  logic [ADDR_WIDTH-1:0] c1_req_addr,
   input  logic [DATA_WIDTH-1:0] c1_req_wdata,
   output logic                  c1_rsp_valid,
   output logic [DATA_WIDTH-1:0] c1_rsp_data,
   input  logic                  r_req_valid,
   output logic                  r_req_ready,
   input  logic [ADDR_WIDTH-1:0] r_req_addr,
   output logic                  r_rsp_valid,
   output logic [DATA_WIDTH-1:0] r_rsp_data,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  rr_ptr;
   logic                  gnt0, gnt1, gnt_we, contest, rd0_acc, rd1_acc, collide;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_wdata;
   logic                  p0_vld, p0_own, p1_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_INIT && init_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_RUN;
   end

   // Macro controls are combinational; rst forces them idle even though state sits in INIT.
   always_comb begin
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      contest      = 1'b0;
      gnt_we       = 1'b0;
      gnt_addr     = c0_req_addr;
      gnt_wdata    = c0_req_wdata;
      collide      = 1'b0;
      rd0_acc      = 1'b0;
      rd1_acc      = 1'b0;
      c0_req_ready = 1'b0;
      c1_req_ready = 1'b0;
      r_req_ready  = 1'b0;
      sram_csb0    = 1'b1;
      sram_web0    = 1'b1;
      sram_addr0   = '0;
      sram_din0    = '0;
      sram_csb1    = 1'b1;
      sram_addr1   = r_req_addr;
      if (!rst) begin
         if (state == ST_INIT) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = init_cnt;
            sram_din0  = INIT_VALUE;
         end else begin
            contest = c0_req_valid && c1_req_valid;
            gnt0    = c0_req_valid && (!c1_req_valid || !rr_ptr);
            gnt1    = c1_req_valid && (!c0_req_valid || rr_ptr);
            if (gnt1) begin
               gnt_we    = c1_req_we;
               gnt_addr  = c1_req_addr;
               gnt_wdata = c1_req_wdata;
            end else begin
               gnt_we    = gnt0 && c0_req_we;
            end
            c0_req_ready = gnt0;
            c1_req_ready = gnt1;
            rd0_acc      = (gnt0 || gnt1) && !gnt_we;
            if (gnt0 || gnt1) begin
               sram_csb0  = 1'b0;
               sram_web0  = ~gnt_we;
               sram_addr0 = gnt_addr;
               sram_din0  = gnt_wdata;
            end
            // A same-cycle write and port-1 read of one address race inside the macro.
            collide     = gnt_we && (gnt_addr == r_req_addr);
            rd1_acc     = r_req_valid && !collide;
            r_req_ready = rd1_acc;
            sram_csb1   = ~rd1_acc;
         end
      end
   end

   assign init_done = (state == ST_RUN);

   // Tag stage marks the cycle in which macro dout holds data worth capturing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr       <= 1'b0;
         p0_vld       <= 1'b0;
         p0_own       <= 1'b0;
         p1_vld       <= 1'b0;
         c0_rsp_valid <= 1'b0;
         c1_rsp_valid <= 1'b0;
         r_rsp_valid  <= 1'b0;
         c0_rsp_data  <= '0;
         c1_rsp_data  <= '0;
         r_rsp_data   <= '0;
      end else begin
         if (contest) rr_ptr <= ~rr_ptr;
         p0_vld       <= rd0_acc;
         p0_own       <= gnt1;
         p1_vld       <= rd1_acc;
         c0_rsp_valid <= p0_vld && !p0_own;
         c1_rsp_valid <= p0_vld && p0_own;
         r_rsp_valid  <= p1_vld;
         if (p0_vld && !p0_own) c0_rsp_data <= sram_dout0;
         if (p0_vld && p0_own)  c1_rsp_data <= sram_dout0;
         if (p1_vld)            r_rsp_data  <= sram_dout1;
      end
   end

endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// Directed bench for sram_1rw1r_arbiter with a cycle-level 1RW+1R macro model
// (inputs registered at posedge, write then read at negedge).
module tb_sram_1rw1r_arbiter;
   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init_done;
   logic          c0_req_valid, c0_req_ready, c0_req_we, c0_rsp_valid;
   logic [AW-1:0] c0_req_addr;
   logic [DW-1:0] c0_req_wdata, c0_rsp_data;
   logic          c1_req_valid, c1_req_ready, c1_req_we, c1_rsp_valid;
   logic [AW-1:0] c1_req_addr;
   logic [DW-1:0] c1_req_wdata, c1_rsp_data;
   logic          r_req_valid, r_req_ready, r_rsp_valid;
   logic [AW-1:0] r_req_addr;
   logic [DW-1:0] r_rsp_data;
   logic          sram_csb0, sram_web0, sram_csb1;
   logic [AW-1:0] sram_addr0, sram_addr1;
   logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sram_1rw1r_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(8'h00)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_we(c0_req_we),
      .c0_req_addr(c0_req_addr), .c0_req_wdata(c0_req_wdata),
      .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
      .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_we(c1_req_we),
      .c1_req_addr(c1_req_addr), .c1_req_wdata(c1_req_wdata),
      .c1_rsp_valid(c1_rsp_valid), .c1_rsp_data(c1_rsp_data),
      .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
      .r_rsp_valid(r_rsp_valid), .r_rsp_data(r_rsp_data),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
      .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
   );

   // Macro model
   logic [DW-1:0] mem [1<<AW];
   logic          m_csb0, m_web0, m_csb1;
   logic [AW-1:0] m_a0, m_a1;
   logic [DW-1:0] m_d0;

   always @(posedge clk) begin
      m_csb0     <= sram_csb0;
      m_web0     <= sram_web0;
      m_a0       <= sram_addr0;
      m_d0       <= sram_din0;
      m_csb1     <= sram_csb1;
      m_a1       <= sram_addr1;
      sram_dout0 <= 'x;
      sram_dout1 <= 'x;
   end

   always @(negedge clk) begin
      if (!m_csb0 && !m_web0) mem[m_a0] = m_d0;
      if (!m_csb0 && m_web0)  sram_dout0 <= mem[m_a0];
      if (!m_csb1)            sram_dout1 <= mem[m_a1];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      c0_req_valid = 1'b0; c0_req_we = 1'b0; c0_req_addr = '0; c0_req_wdata = '0;
      c1_req_valid = 1'b0; c1_req_we = 1'b0; c1_req_addr = '0; c1_req_wdata = '0;
      r_req_valid  = 1'b0; r_req_addr = '0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_init_done"}, init_done, 0);
      chk({tag, "_csb0"}, sram_csb0, 1);
      chk({tag, "_web0"}, sram_web0, 1);
      chk({tag, "_csb1"}, sram_csb1, 1);
      chk({tag, "_rdy"}, {c0_req_ready, c1_req_ready, r_req_ready}, 0);
      chk({tag, "_rvld"}, {c0_rsp_valid, c1_rsp_valid, r_rsp_valid}, 0);
      chk({tag, "_rdata"}, {c0_rsp_data, c1_rsp_data, r_rsp_data}, 0);
   endtask

   // Holds rst two cycles, releases it, and checks the 16-cycle clear sequence.
   task automatic init_seq;
      rst = 1'b1;
      c0_req_valid = 1'b1; r_req_valid = 1'b1;
      step();
      #1 chk_reset("rst_a");
      step();
      #1 chk_reset("rst_b");
      step();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("init_addr", sram_addr0, i);
         chk("init_csb_web", {sram_csb0, sram_web0, sram_csb1}, 3'b001);
         chk("init_din", sram_din0, 8'h00);
         chk("init_done_lo", init_done, 0);
         chk("init_rdy", {c0_req_ready, r_req_ready}, 0);
         if (i == 15) idle();
         step();
      end
      #1 chk("init_done_hi", init_done, 1);
      step();
   endtask

   function automatic logic [7:0] t5_exp(input int j);
      if (j >= 8) return 8'(8'hC0 + j - 8);
      case (j)
         3:       return 8'hA5;
         5:       return 8'h5A;
         7:       return 8'h3C;
         default: return 8'h00;
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle();
      init_seq();

      // Write 3 = A5, read back next cycle
      c0_req_valid = 1'b1; c0_req_we = 1'b1; c0_req_addr = 4'd3; c0_req_wdata = 8'hA5;
      #1 chk("t2_wr_rdy", c0_req_ready, 1);
      chk("t2_web0", sram_web0, 0);
      step();
      c0_req_we = 1'b0;
      #1 chk("t2_rd_rdy", c0_req_ready, 1);
      step();
      idle();
      #1 chk("t2_vld_k2", c0_rsp_valid, 0);
      step();
      #1 chk("t2_vld_k3", c0_rsp_valid, 1);
      chk("t2_data", c0_rsp_data, 8'hA5);
      step();
      #1 chk("t2_vld_off", c0_rsp_valid, 0);
      chk("t2_hold", c0_rsp_data, 8'hA5);

      // c1 writes 5 = 5A, then contested reads alternate
      c1_req_valid = 1'b1; c1_req_we = 1'b1; c1_req_addr = 4'd5; c1_req_wdata = 8'h5A;
      #1 chk("t3_wr_rdy", c1_req_ready, 1);
      step();
      for (int j = 0; j < 6; j++) begin
         if (j < 4) begin
            c0_req_valid = 1'b1; c0_req_we = 1'b0; c0_req_addr = 4'd3;
            c1_req_valid = 1'b1; c1_req_we = 1'b0; c1_req_addr = 4'd5;
         end else idle();
         #1;
         if (j < 4) chk("t3_gnt", {c0_req_ready, c1_req_ready}, (j % 2 == 0) ? 2'b10 : 2'b01);
         if (j >= 2) begin
            chk("t3_rsp", {c0_rsp_valid, c1_rsp_valid}, (j % 2 == 0) ? 2'b10 : 2'b01);
            if (j % 2 == 0) chk("t3_c0_data", c0_rsp_data, 8'hA5);
            else            chk("t3_c1_data", c1_rsp_data, 8'h5A);
         end
         step();
      end
      #1 chk("t3_rsp_off", {c0_rsp_valid, c1_rsp_valid}, 0);

      // Write/read collision on addr 7
      c1_req_valid = 1'b1; c1_req_we = 1'b1; c1_req_addr = 4'd7; c1_req_wdata = 8'h3C;
      r_req_valid = 1'b1; r_req_addr = 4'd7;
      #1 chk("t4_c1_rdy", c1_req_ready, 1);
      chk("t4_stall", {r_req_ready, sram_csb1}, 2'b01);
      step();
      c1_req_valid = 1'b0;
      #1 chk("t4_accept", {r_req_ready, sram_csb1}, 2'b10);
      step();
      idle();
      #1 chk("t4_vld_early", r_rsp_valid, 0);
      step();
      #1 chk("t4_vld", r_rsp_valid, 1);
      chk("t4_data", r_rsp_data, 8'h3C);
      step();

      // r streams 0..15 while c0 writes the opposite half
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            r_req_valid = 1'b1; r_req_addr = 4'(i);
            c0_req_valid = 1'b1; c0_req_we = 1'b1; c0_req_addr = 4'(i + 8);
            c0_req_wdata = 8'(8'hC0 + i);
         end else idle();
         #1;
         if (i < 16) chk("t5_rdy", {r_req_ready, c0_req_ready}, 2'b11);
         if (i >= 2) begin
            chk("t5_vld", r_rsp_valid, 1);
            chk("t5_data", r_rsp_data, t5_exp(i - 2));
         end
         step();
      end
      #1 chk("t5_vld_off", r_rsp_valid, 0);

      // Reset one cycle after an accepted read
      c0_req_valid = 1'b1; c0_req_we = 1'b0; c0_req_addr = 4'd3;
      #1 chk("t6_rdy", c0_req_ready, 1);
      step();
      idle();
      rst = 1'b1;
      #1 chk_reset("t6_rst");
      init_seq();

      // After the clear every address reads back INIT_VALUE
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            c0_req_valid = 1'b1; c0_req_we = 1'b0; c0_req_addr = 4'(i);
         end else idle();
         #1;
         if (i < 16) chk("t1_rdy", c0_req_ready, 1);
         if (i >= 2) begin
            chk("t1_vld", c0_rsp_valid, 1);
            chk("t1_data", c0_rsp_data, 8'h00);
         end
         step();
      end
      #1 chk("t1_vld_off", c0_rsp_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
